// File: rtl/loop_load_seq_if.sv
// Loop-control, memory read port and element stream bundle for loop_load_seq.
// Widths must match the parameters of the loop_load_seq instance the bundle is bound to.
interface loop_load_seq_if #(
    parameter int ADDR_W = 6,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] array_base;
    logic [IDX_W-1:0]  trip_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_data;
    logic              elem_valid;
    logic [DATA_W-1:0] elem_data;
    logic [ACC_W-1:0]  sum;

    modport master (
        output start, array_base, trip_count, mem_data,
        input  busy, done, mem_addr, mem_rd_en, elem_valid, elem_data, sum
    );

    modport slave (
        input  start, array_base, trip_count, mem_data,
        output busy, done, mem_addr, mem_rd_en, elem_valid, elem_data, sum
    );
endinterface

// File: rtl/loop_load_seq.sv
// Strided array-load driver: one read per cycle at base+((idx+1)<<STRIDE_SHIFT), streams and sums returns.
// done arrives trip_count+MEM_LAT+1 cycles after start; no backpressure, memory and sink must always accept.
module loop_load_seq #(
    parameter int ADDR_W       = 6,
    parameter int IDX_W        = 4,
    parameter int DATA_W       = 4,
    parameter int STRIDE_SHIFT = 2,
    parameter int MEM_LAT      = 1,
    parameter int ACC_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    loop_load_seq_if.slave bus
);
    localparam int OFF_W = IDX_W + 1 + STRIDE_SHIFT;
    localparam int SUM_W = (OFF_W > ADDR_W) ? OFF_W : ADDR_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  trip_q;
    logic [IDX_W-1:0]  idx_q;
    logic [MEM_LAT-1:0] pipe_q;
    logic [MEM_LAT-1:0] pipe_rest;
    logic              rsp_vld;
    logic              issue_last;
    logic              drained;
    logic              start_acc;
    logic [IDX_W:0]    idx_p1;
    logic [SUM_W-1:0]  addr_full;
    logic              elem_valid_q;
    logic [DATA_W-1:0] elem_data_q;
    logic [ACC_W-1:0]  sum_q;

    assign start_acc  = (state_q == IDLE) && bus.start;
    assign issue_last = (idx_q == trip_q - IDX_W'(1));
    assign rsp_vld    = pipe_q[MEM_LAT-1];

    // Drain ends once the only tag left is the one emerging this cycle.
    always_comb begin
        pipe_rest            = pipe_q;
        pipe_rest[MEM_LAT-1] = 1'b0;
    end
    assign drained = (pipe_rest == '0);

    // (idx+1) is formed one bit wider so idx at full scale still yields a distinct offset before wrapping.
    assign idx_p1    = {1'b0, idx_q} + (IDX_W + 1)'(1);
    assign addr_full = SUM_W'(base_q) + (SUM_W'(idx_p1) << STRIDE_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.trip_count == '0) ? DONE : ISSUE;
            ISSUE:   if (issue_last) state_d = DRAIN;
            DRAIN:   if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
        bus.done      = (state_q == DONE);
        bus.mem_rd_en = (state_q == ISSUE);
        bus.mem_addr  = '0;
        if (state_q == ISSUE) begin
            bus.mem_addr = addr_full[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            trip_q       <= '0;
            idx_q        <= '0;
            pipe_q       <= '0;
            elem_valid_q <= 1'b0;
            elem_data_q  <= '0;
            sum_q        <= '0;
        end else begin
            pipe_q       <= (pipe_q << 1) | MEM_LAT'(state_q == ISSUE);
            elem_valid_q <= rsp_vld;
            if (start_acc) begin
                base_q <= bus.array_base;
                trip_q <= bus.trip_count;
                idx_q  <= '0;
                pipe_q <= '0;
                sum_q  <= '0;
            end
            if (state_q == ISSUE) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (rsp_vld) begin
                elem_data_q <= bus.mem_data;
                sum_q       <= sum_q + ACC_W'(bus.mem_data);
            end
        end
    end

    assign bus.elem_valid = elem_valid_q;
    assign bus.elem_data  = elem_data_q;
    assign bus.sum        = sum_q;
endmodule

// File: tb/tb_loop_load_seq.sv
// Runs a MEM_LAT=1 and a MEM_LAT=2 instance side by side on shared stimulus against a cycle-indexed model.
module tb_loop_load_seq;
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic [5:0] addr;
        logic       ev;
        logic [3:0] ed;
        logic [7:0] sum;
    } obs_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat [2] = '{1, 2};
    int   cur_mode = 0;

    logic [3:0] rmem [64];
    logic [3:0] ed_hold  [2];
    logic [7:0] sum_hold [2];
    obs_t       obs [2];

    loop_load_seq_if #(.ADDR_W(6), .IDX_W(4), .DATA_W(4), .ACC_W(8)) b1 ();
    loop_load_seq_if #(.ADDR_W(6), .IDX_W(4), .DATA_W(4), .ACC_W(8)) b2 ();

    loop_load_seq #(.ADDR_W(6), .IDX_W(4), .DATA_W(4), .STRIDE_SHIFT(2), .MEM_LAT(1), .ACC_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    loop_load_seq #(.ADDR_W(6), .IDX_W(4), .DATA_W(4), .STRIDE_SHIFT(2), .MEM_LAT(2), .ACC_W(8))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    assign obs[0] = {b1.busy, b1.done, b1.mem_rd_en, b1.mem_addr, b1.elem_valid, b1.elem_data, b1.sum};
    assign obs[1] = {b2.busy, b2.done, b2.mem_rd_en, b2.mem_addr, b2.elem_valid, b2.elem_data, b2.sum};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] mval(input int mode, input logic [5:0] a);
        case (mode)
            1:       return a[5:2];
            2:       return 4'hF;
            default: return rmem[a];
        endcase
    endfunction

    // Memory model: answers each read exactly its instance's latency later, junk otherwise.
    logic       e1_p = 1'b0, e2_p1 = 1'b0, e2_p2 = 1'b0;
    logic [5:0] a1_p = '0, a2_p1 = '0, a2_p2 = '0;
    always @(negedge clk) begin
        b1.mem_data = e1_p ? mval(cur_mode, a1_p) : 4'($urandom);
        e1_p = b1.mem_rd_en;
        a1_p = b1.mem_addr;
        b2.mem_data = e2_p2 ? mval(cur_mode, a2_p2) : 4'($urandom);
        e2_p2 = e2_p1;
        a2_p2 = a2_p1;
        e2_p1 = b2.mem_rd_en;
        a2_p1 = b2.mem_addr;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_inst(input int i, input string ph, input int c, input obs_t e);
        obs_t  o;
        string p;
        o = obs[i];
        p = $sformatf("%s L%0d c%0d", ph, lat[i], c);
        check({p, " busy"}, o.busy, e.busy);
        check({p, " done"}, o.done, e.done);
        check({p, " mem_rd_en"}, o.rd, e.rd);
        check({p, " mem_addr"}, o.addr, e.addr);
        check({p, " elem_valid"}, o.ev, e.ev);
        check({p, " elem_data"}, o.ed, e.ed);
        check({p, " sum"}, o.sum, e.sum);
    endtask

    task automatic drive(input logic s, input logic [5:0] base, input logic [3:0] trip);
        b1.start = s;  b1.array_base = base;  b1.trip_count = trip;
        b2.start = s;  b2.array_base = base;  b2.trip_count = trip;
    endtask

    task automatic check_idle(input string ph, input int c);
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            e = '{busy: 1'b0, done: 1'b0, rd: 1'b0, addr: 6'd0, ev: 1'b0, ed: ed_hold[i], sum: sum_hold[i]};
            check_inst(i, ph, c, e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_idle("idle", j);
            drive(1'b0, 6'($urandom), 4'($urandom));
        end
    endtask

    // Cycle c counts from the cycle start is held high (c=0), matching the loop's own cycle numbering.
    task automatic run_txn(input logic [5:0] base, input logic [3:0] trip, input int mode,
                           input int ign_at, input int rst_at, input string ph);
        obs_t e;
        int   n, last, L, k;
        int   dones [2];
        int   evs   [2];
        logic [3:0] v;
        n = trip;
        last = n + 3;
        dones = '{0, 0};
        evs = '{0, 0};
        cur_mode = mode;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                L = lat[i];
                if (c == 1) sum_hold[i] = 8'd0;
                e.busy = (n > 0) && (c >= 1) && (c <= n + L);
                e.done = (n == 0) ? (c == 1) : (c == n + L + 1);
                e.rd   = (c >= 1) && (c <= n);
                e.addr = e.rd ? 6'(base + 6'(c * 4)) : 6'd0;
                e.ev   = (n > 0) && (c >= L + 2) && (c <= n + L + 1);
                if (e.ev) begin
                    k = c - L - 1;
                    v = mval(mode, 6'(base + 6'(k * 4)));
                    ed_hold[i] = v;
                    sum_hold[i] = sum_hold[i] + 8'(v);
                end
                e.ed  = ed_hold[i];
                e.sum = sum_hold[i];
                check_inst(i, ph, c, e);
                if (obs[i].done) dones[i]++;
                if (obs[i].ev) evs[i]++;
            end
            if (c == 0) drive(1'b1, base, trip);
            else drive(c == ign_at, 6'($urandom), 4'($urandom));
            if (c == rst_at) begin
                rst = 1'b1;
                drive(1'b0, 6'($urandom), 4'($urandom));
                break;
            end
        end
        if (rst_at >= 0) begin
            ed_hold  = '{4'd0, 4'd0};
            sum_hold = '{8'd0, 8'd0};
            @(negedge clk);
            check_idle({ph, " in reset"}, rst_at + 1);
            rst = 1'b0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check_idle({ph, " after reset"}, rst_at + 2 + j);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("%s L%0d done count", ph, lat[i]), dones[i], 1);
                check($sformatf("%s L%0d elem count", ph, lat[i]), evs[i], n);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ign, nt;
        logic [3:0] t;
        for (int a = 0; a < 64; a++) rmem[a] = 4'($urandom);
        ed_hold  = '{4'd0, 4'd0};
        sum_hold = '{8'd0, 8'd0};
        rst = 1'b1;
        drive(1'b0, 6'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset", 0);
        rst = 1'b0;
        idle_cycles(1);

        run_txn(6'd0, 4'd3, 1, -1, -1, "trip3");
        run_txn(6'd0, 4'd0, 0, 1, -1, "zero trip");
        run_txn(6'd56, 4'd3, 0, -1, -1, "wrap");
        run_txn(6'd8, 4'd6, 0, 3, -1, "ignored start");
        run_txn(6'd12, 4'd5, 0, -1, 2, "reset mid");
        run_txn(6'd20, 4'd4, 0, -1, -1, "fresh");
        run_txn(6'd0, 4'd15, 2, -1, -1, "full range");
        check("full range L2 sum", obs[1].sum, 225);

        for (int r = 0; r < 30; r++) begin
            t = 4'($urandom_range(0, 15));
            nt = t;
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (nt == 0) ? 1 : nt + 2)) : -1;
            run_txn(6'($urandom), t, 0, ign, -1, $sformatf("rand%0d", r));
            idle_cycles($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
